// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Program-counter register and instruction-fetch sequencer. Drives the
//   external 16-bit adder with (PC, PC_STEP) and takes its sum back as the
//   sequential next PC. Issues req/ack fetches to instruction memory and
//   presents fetched words downstream on a valid/ready handshake. A redirect
//   always wins over increment and over the downstream handshake.
// Ports
//   clk, rst_n                         clock, async active-low reset
//   stall                              block the start of a new fetch
//   redirect_valid, redirect_target    load aligned target into PC
//   add_a, add_b, add_s                adder operands out, sum in
//   imem_req, imem_addr                fetch request / address to memory
//   imem_ack, imem_rdata               fetch completion / instruction word
//   fetch_valid, fetch_ready           downstream handshake
//   fetch_pc, fetch_instr              presented PC and instruction
module pc_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_s,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [15:0] fetch_pc,
    output logic [31:0] fetch_instr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        VALID
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] req_addr;
    logic        drop;
    logic [15:0] target_aligned;

    assign target_aligned = {redirect_target[15:2], 2'b00};
    assign add_a          = pc;
    assign add_b          = PC_STEP;
    assign imem_addr      = req_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            drop        <= 1'b0;
            imem_req    <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_instr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc <= target_aligned;
                    end else if (!stall) begin
                        req_addr <= pc;
                        imem_req <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // An open request is never withdrawn; a redirect while
                    // waiting marks the eventual response for discard.
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (drop || redirect_valid) begin
                            drop  <= 1'b0;
                            state <= IDLE;
                            if (redirect_valid) begin
                                pc <= target_aligned;
                            end
                        end else begin
                            fetch_instr <= imem_rdata;
                            fetch_pc    <= req_addr;
                            fetch_valid <= 1'b1;
                            pc          <= add_s;
                            state       <= VALID;
                        end
                    end else if (redirect_valid) begin
                        pc   <= target_aligned;
                        drop <= 1'b1;
                    end
                end
                VALID: begin
                    // Redirect squashes the presented word even if accepted.
                    if (redirect_valid) begin
                        fetch_valid <= 1'b0;
                        pc          <= target_aligned;
                        state       <= IDLE;
                    end else if (fetch_ready) begin
                        fetch_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
